// File: rtl/wb_commit_regfile.sv
// Write-back stage: 2-entry MEM->WB buffer that retires in order into the GPR file,
// with decode read ports, commit bypass, pending-write flags and a retire trace.
module wb_commit_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_N  = 32,
    parameter int CNT_W  = 64,
    localparam int RA_W  = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [31:0]       in_inst,
    input  logic [DATA_W-1:0] in_rw_data,
    input  logic [RA_W-1:0]   in_rw_addr,
    input  logic              in_rw_en,
    input  logic              stall,
    input  logic [RA_W-1:0]   ra1,
    input  logic [RA_W-1:0]   ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              pend1,
    output logic              pend2,
    output logic              commit_valid,
    output logic [ADDR_W-1:0] commit_pc,
    output logic [31:0]       commit_inst,
    output logic              commit_we,
    output logic [CNT_W-1:0]  commit_cnt
);

    logic [ADDR_W-1:0] fifo_pc   [2];
    logic [31:0]       fifo_inst [2];
    logic [DATA_W-1:0] fifo_data [2];
    logic [RA_W-1:0]   fifo_addr [2];
    logic [1:0]        fifo_we;

    logic              head, tail, nxt;
    logic [1:0]        count;
    logic [DATA_W-1:0] gpr [REG_N];

    logic acc, cmt;
    logic head_busy, nxt_busy;

    assign in_ready = (count < 2'd2);
    assign acc      = in_valid & in_ready;
    assign cmt      = (count != 2'd0) & ~stall;
    assign nxt      = ~head;

    // Control state and the architectural file; both cleared together on rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            head       <= 1'b0;
            tail       <= 1'b0;
            commit_cnt <= '0;
            for (int i = 0; i < REG_N; i++) gpr[i] <= '0;
        end else begin
            if (acc) tail <= ~tail;
            if (cmt) begin
                head       <= ~head;
                commit_cnt <= commit_cnt + CNT_W'(1);
                if (fifo_we[head]) gpr[fifo_addr[head]] <= fifo_data[head];
            end
            case ({acc, cmt})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload slots carry no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (acc) begin
            fifo_pc[tail]   <= in_pc;
            fifo_inst[tail] <= in_inst;
            fifo_data[tail] <= in_rw_data;
            fifo_addr[tail] <= in_rw_addr;
            fifo_we[tail]   <= in_rw_en & (in_rw_addr != '0);
        end
    end

    assign commit_valid = cmt;
    assign commit_pc    = fifo_pc[head];
    assign commit_inst  = fifo_inst[head];
    assign commit_we    = fifo_we[head];

    // Write-first bypass: a retiring write is visible to decode in the same cycle.
    assign rd1 = (ra1 == '0) ? '0 :
                 (cmt & fifo_we[head] & (fifo_addr[head] == ra1)) ? fifo_data[head] : gpr[ra1];
    assign rd2 = (ra2 == '0) ? '0 :
                 (cmt & fifo_we[head] & (fifo_addr[head] == ra2)) ? fifo_data[head] : gpr[ra2];

    // The head only blocks decode while it is frozen; the second slot always does.
    assign head_busy = (count != 2'd0) & stall & fifo_we[head];
    assign nxt_busy  = (count == 2'd2) & fifo_we[nxt];

    assign pend1 = (ra1 != '0) & ((head_busy & (fifo_addr[head] == ra1)) |
                                  (nxt_busy  & (fifo_addr[nxt]  == ra1)));
    assign pend2 = (ra2 != '0) & ((head_busy & (fifo_addr[head] == ra2)) |
                                  (nxt_busy  & (fifo_addr[nxt]  == ra2)));

endmodule

// File: tb/tb_wb_commit_regfile.sv
// Bench for wb_commit_regfile: hand-computed vector table for the directed cases,
// then randomized traffic checked against a queue-based retire model.
module tb_wb_commit_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic [31:0] in_rw_data;
    logic [4:0]  in_rw_addr;
    logic        in_rw_en;
    logic        stall;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic        pend1, pend2;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_inst;
    logic        commit_we;
    logic [63:0] commit_cnt;

    always #5 clk = ~clk;

    wb_commit_regfile dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_rw_data(in_rw_data),
        .in_rw_addr(in_rw_addr), .in_rw_en(in_rw_en),
        .stall(stall), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .pend1(pend1), .pend2(pend2),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .commit_we(commit_we), .commit_cnt(commit_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc, inst, data;
        logic [4:0]  addr;
        logic        en;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_gpr [32];
    logic [63:0] m_cnt;
    bit          model_ok = 0;

    function automatic logic [31:0] m_read(input logic [4:0] ra, input bit cm);
        if (ra == 0) return 32'h0;
        if (cm && q[0].en && q[0].addr == ra) return q[0].data;
        return m_gpr[ra];
    endfunction

    function automatic bit m_pend(input logic [4:0] ra, input bit cm);
        for (int i = 0; i < q.size(); i++)
            if (ra != 0 && q[i].en && q[i].addr == ra && !(i == 0 && cm)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_check();
        bit cm;
        cm = (q.size() != 0) && !stall;
        check("ready", in_ready, q.size() < 2);
        check("commit_valid", commit_valid, cm);
        if (cm) begin
            check("commit_pc", commit_pc, q[0].pc);
            check("commit_inst", commit_inst, q[0].inst);
            check("commit_we", commit_we, q[0].en && q[0].addr != 0);
        end
        check("rd1", rd1, m_read(ra1, cm));
        check("rd2", rd2, m_read(ra2, cm));
        check("pend1", pend1, m_pend(ra1, cm));
        check("pend2", pend2, m_pend(ra2, cm));
        check("commit_cnt", commit_cnt, m_cnt);
    endtask

    task automatic model_update();
        ent_t e;
        bit   rdy, cm;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
            m_cnt    = 64'h0;
            model_ok = 1;
        end else begin
            rdy = q.size() < 2;
            cm  = (q.size() != 0) && !stall;
            if (cm) begin
                e = q.pop_front();
                if (e.en && e.addr != 0) m_gpr[e.addr] = e.data;
                m_cnt++;
            end
            if (in_valid && rdy) begin
                e.pc = in_pc; e.inst = in_inst; e.data = in_rw_data;
                e.addr = in_rw_addr; e.en = in_rw_en;
                q.push_back(e);
            end
        end
    endtask

    // One clock: sample mid-cycle, then advance model past the edge.
    task automatic run_cycle();
        if (model_ok) model_check();
        @(posedge clk);
        #1;
        model_update();
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          chk, rst, vld;
        logic [4:0]  addr;
        logic [31:0] data;
        bit          en, stall;
        logic [4:0]  ra1, ra2;
        bit          rdy, cv, cwe;
        logic [31:0] rd1;
        bit          p1, p2;
        logic [63:0] cnt;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    function automatic vec_t mk(input bit c, r, v, input logic [4:0] a, input logic [31:0] d,
                                input bit e, s, input logic [4:0] r1, r2,
                                input bit rdy, cv, cwe, input logic [31:0] rd,
                                input bit p1, p2, input logic [63:0] cnt);
        vec_t x;
        x.chk = c; x.rst = r; x.vld = v; x.addr = a; x.data = d; x.en = e; x.stall = s;
        x.ra1 = r1; x.ra2 = r2; x.rdy = rdy; x.cv = cv; x.cwe = cwe; x.rd1 = rd;
        x.p1 = p1; x.p2 = p2; x.cnt = cnt;
        return x;
    endfunction

    initial begin
        //             chk rst vld addr data          en stl ra1 ra2  rdy cv cwe rd1           p1 p2 cnt
        tbl[0]  = mk(0, 1, 0, 0, 32'h0,        0, 0, 5, 0,  1, 0, 0, 32'h0,        0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 0, 32'h0,        0, 0, 5, 0,  1, 0, 0, 32'h0,        0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 32'h0,        0, 0, 5, 0,  1, 0, 0, 32'h0,        0, 0, 0);
        tbl[3]  = mk(1, 0, 1, 5, 32'hDEADBEEF, 1, 0, 5, 0,  1, 0, 0, 32'h0,        0, 0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 32'h0,        0, 0, 5, 0,  1, 1, 1, 32'hDEADBEEF, 0, 0, 0);
        tbl[5]  = mk(1, 0, 0, 0, 32'h0,        0, 0, 5, 0,  1, 0, 0, 32'hDEADBEEF, 0, 0, 1);
        tbl[6]  = mk(1, 0, 1, 0, 32'h1234,     1, 0, 0, 0,  1, 0, 0, 32'h0,        0, 0, 1);
        tbl[7]  = mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 0,  1, 1, 0, 32'h0,        0, 0, 1);
        tbl[8]  = mk(1, 0, 0, 0, 32'h0,        0, 0, 5, 0,  1, 0, 0, 32'hDEADBEEF, 0, 0, 2);
        tbl[9]  = mk(1, 0, 1, 9, 32'h99,       1, 1, 9, 10, 1, 0, 0, 32'h0,        0, 0, 2);
        tbl[10] = mk(1, 0, 1, 10, 32'hAA,      1, 1, 9, 10, 1, 0, 0, 32'h0,        1, 0, 2);
        tbl[11] = mk(1, 0, 1, 11, 32'hBB,      1, 1, 9, 10, 0, 0, 0, 32'h0,        1, 1, 2);
        tbl[12] = mk(1, 0, 1, 11, 32'hBB,      1, 1, 9, 10, 0, 0, 0, 32'h0,        1, 1, 2);
        tbl[13] = mk(1, 0, 1, 11, 32'hBB,      1, 0, 9, 10, 0, 1, 1, 32'h99,       0, 1, 2);
        tbl[14] = mk(1, 0, 1, 11, 32'hBB,      1, 0, 9, 10, 1, 1, 1, 32'h99,       0, 0, 3);
        tbl[15] = mk(1, 0, 0, 0, 32'h0,        0, 0, 11, 10, 1, 1, 1, 32'hBB,      0, 0, 4);
        tbl[16] = mk(1, 0, 0, 0, 32'h0,        0, 0, 9, 0,  1, 0, 0, 32'h99,       0, 0, 5);
        tbl[17] = mk(1, 0, 1, 7, 32'h1,        1, 1, 7, 0,  1, 0, 0, 32'h0,        0, 0, 5);
        tbl[18] = mk(1, 0, 1, 7, 32'h2,        1, 1, 7, 0,  1, 0, 0, 32'h0,        1, 0, 5);
        tbl[19] = mk(1, 0, 0, 0, 32'h0,        0, 0, 7, 0,  0, 1, 1, 32'h1,        1, 0, 5);
        tbl[20] = mk(1, 0, 0, 0, 32'h0,        0, 0, 7, 0,  1, 1, 1, 32'h2,        0, 0, 6);
        tbl[21] = mk(1, 0, 0, 0, 32'h0,        0, 0, 7, 0,  1, 0, 0, 32'h2,        0, 0, 7);
        tbl[22] = mk(1, 0, 1, 3, 32'h33,       1, 1, 7, 0,  1, 0, 0, 32'h2,        0, 0, 7);
        tbl[23] = mk(1, 0, 1, 4, 32'h44,       1, 1, 7, 0,  1, 0, 0, 32'h2,        0, 0, 7);
        tbl[24] = mk(1, 1, 0, 0, 32'h0,        0, 1, 7, 0,  0, 0, 0, 32'h2,        0, 0, 7);
        tbl[25] = mk(1, 0, 0, 0, 32'h0,        0, 0, 7, 3,  1, 0, 0, 32'h0,        0, 0, 0);
        tbl[26] = mk(1, 0, 0, 0, 32'h0,        0, 0, 4, 0,  1, 0, 0, 32'h0,        0, 0, 0);

        rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; in_rw_data = '0;
        in_rw_addr = '0; in_rw_en = 1'b0; stall = 1'b0; ra1 = '0; ra2 = '0;

        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst; in_valid = tbl[i].vld; in_rw_addr = tbl[i].addr;
            in_rw_data = tbl[i].data; in_rw_en = tbl[i].en; stall = tbl[i].stall;
            ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
            in_pc = 32'h1c000000 + 32'(4 * i); in_inst = 32'(i);
            #3;
            if (tbl[i].chk) begin
                check($sformatf("v%0d.ready", i), in_ready, tbl[i].rdy);
                check($sformatf("v%0d.cvalid", i), commit_valid, tbl[i].cv);
                if (tbl[i].cv) check($sformatf("v%0d.cwe", i), commit_we, tbl[i].cwe);
                check($sformatf("v%0d.rd1", i), rd1, tbl[i].rd1);
                check($sformatf("v%0d.pend1", i), pend1, tbl[i].p1);
                check($sformatf("v%0d.pend2", i), pend2, tbl[i].p2);
                check($sformatf("v%0d.cnt", i), commit_cnt, tbl[i].cnt);
            end
            run_cycle();
        end

        // Randomized traffic with hazards concentrated on r0..r7.
        for (int n = 0; n < 2000; n++) begin
            rst        = ($urandom_range(0, 149) == 0);
            in_valid   = ($urandom_range(0, 2) != 0);
            in_pc      = $urandom;
            in_inst    = $urandom;
            in_rw_data = $urandom;
            in_rw_addr = 5'($urandom_range(0, 7));
            in_rw_en   = ($urandom_range(0, 3) != 0);
            stall      = ($urandom_range(0, 3) == 0);
            ra1        = 5'($urandom_range(0, 7));
            ra2        = 5'($urandom_range(0, 7));
            #3;
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
